// File: rtl/sodor_dmem_subword_adapter.sv
// Sodor data-port adapter onto word-only dmem: extended B/H/W loads, read-modify-write sub-word stores.
// Latency accept->resp: load 3, word store 2, sub-word store 4, error 1; one access in flight, req_ready low while busy.
module sodor_dmem_subword_adapter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit STORE_RESP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_fcn,
  input  logic [2:0]        req_typ,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_data,
  output logic              dmem_req_write_en,
  input  logic [DATA_W-1:0] dmem_resp_data
);

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_W  = 3'd3;
  localparam logic [2:0] TYP_BU = 3'd5;
  localparam logic [2:0] TYP_HU = 3'd6;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP} state_t;

  // Only the fields the later states need; the word address and word store data
  // go straight to the dmem registers at accept time.
  typedef struct packed {
    logic [2:0]  typ;
    logic [1:0]  lane;
    logic [15:0] sdata;
    logic        store;
    logic        err;
  } req_t;

  state_t            state;
  req_t              cur;
  logic [DATA_W-1:0] rd_word;
  logic              accept;
  logic              typ_ok;
  logic              misaligned;
  logic              req_err;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;
  logic [DATA_W-1:0] wr_merge;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    typ_ok     = 1'b1;
    misaligned = 1'b0;
    case (req_typ)
      TYP_B, TYP_BU: misaligned = 1'b0;
      TYP_H, TYP_HU: misaligned = req_addr[0];
      TYP_W:         misaligned = |req_addr[1:0];
      default:       typ_ok     = 1'b0;
    endcase
    req_err = !typ_ok || misaligned ||
              (req_fcn && (req_typ == TYP_BU || req_typ == TYP_HU));
  end

  always_comb begin
    ld_byte = rd_word[{cur.lane, 3'b000} +: 8];
    ld_half = rd_word[{cur.lane[1], 4'b0000} +: 16];
    case (cur.typ)
      TYP_B:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      TYP_BU:  ld_val = {24'h0, ld_byte};
      TYP_H:   ld_val = {{16{ld_half[15]}}, ld_half};
      TYP_HU:  ld_val = {16'h0, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  // Only B and H stores reach RMW_WAIT, so anything not B is a half merge.
  always_comb begin
    wr_merge = dmem_resp_data;
    if (cur.typ == TYP_B)
      wr_merge[{cur.lane, 3'b000} +: 8] = cur.sdata[7:0];
    else
      wr_merge[{cur.lane[1], 4'b0000} +: 16] = cur.sdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cur               <= '0;
      rd_word           <= '0;
      resp_valid        <= 1'b0;
      resp_data         <= '0;
      resp_err          <= 1'b0;
      dmem_req_addr     <= '0;
      dmem_req_data     <= '0;
      dmem_req_write_en <= 1'b0;
    end else begin
      resp_valid        <= 1'b0;
      dmem_req_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur.typ   <= req_typ;
            cur.lane  <= req_addr[1:0];
            cur.sdata <= req_data[15:0];
            cur.store <= req_fcn;
            cur.err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else begin
              dmem_req_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (!req_fcn) begin
                state <= RD;
              end else if (req_typ == TYP_W) begin
                dmem_req_data     <= req_data;
                dmem_req_write_en <= 1'b1;
                state             <= WR;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        RD:       state <= RD_WAIT;
        RD_WAIT: begin
          rd_word <= dmem_resp_data;
          state   <= RESP;
        end
        RMW_RD:   state <= RMW_WAIT;
        RMW_WAIT: begin
          dmem_req_data     <= wr_merge;
          dmem_req_write_en <= 1'b1;
          state             <= WR;
        end
        WR:       state <= STORE_RESP ? RESP : IDLE;
        RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= cur.err;
          resp_data  <= (cur.err || cur.store) ? '0 : ld_val;
          state      <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sodor_dmem_subword_adapter.sv
// Randomized and directed bench for sodor_dmem_subword_adapter against a word-memory reference model.
module tb_sodor_dmem_subword_adapter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        req_fcn = 1'b0;
  logic [2:0]  req_typ = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_data;
  logic        dmem_req_write_en;
  logic [31:0] dmem_resp_data = '0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  sodor_dmem_subword_adapter #(.ADDR_W(32), .DATA_W(32), .STORE_RESP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .req_fcn(req_fcn), .req_typ(req_typ),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .dmem_req_addr(dmem_req_addr), .dmem_req_data(dmem_req_data),
    .dmem_req_write_en(dmem_req_write_en), .dmem_resp_data(dmem_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [29:0] i);
    return mem.exists(i) ? mem[i] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  // Word memory: writes on the strobe, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (dmem_req_write_en) mem[dmem_req_addr[31:2]] = dmem_req_data;
    dmem_resp_data <= mem_rd(dmem_req_addr[31:2]);
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]]     = v;
    ref_mem[a[31:2]] = v;
  endtask

  // Access outcome from size/alignment arithmetic on a flat word memory.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic f,
                                input logic [2:0] t, output logic [31:0] e_dat, output logic e_err,
                                output int e_lat, output int e_wr, output logic [31:0] e_word);
    int sz, off, sh;
    logic [31:0] w, mask, v;
    sz = (t == 1 || t == 5) ? 1 : (t == 2 || t == 6) ? 2 : (t == 3) ? 4 : 0;
    off = int'(a[1:0]);
    e_err = 1'b1;
    if (sz != 0) e_err = ((off % sz) != 0) || (f && t > 4);
    w = ref_rd(a[31:2]);
    e_word = w; e_dat = 32'h0; e_wr = 0; e_lat = 1;
    if (!e_err) begin
      sh   = 8 * off;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
      if (!f) begin
        v = (w >> sh) & mask;
        if (t < 4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
        e_dat = v;
        e_lat = 3;
      end else begin
        e_word = (w & ~(mask << sh)) | ((d & mask) << sh);
        e_wr   = 1;
        e_lat  = (sz == 4) ? 2 : 4;
        ref_mem[a[31:2]] = e_word;
      end
    end
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic f,
                        input logic [2:0] t, output logic [31:0] r_dat, output logic r_err,
                        output int r_lat);
    logic [31:0] e_dat, e_word, wa;
    logic e_err, got;
    int e_lat, e_wr, lat, nwr, wc;
    r_dat = 'x; r_err = 1'bx; r_lat = -1;
    model(a, d, f, t, e_dat, e_err, e_lat, e_wr, e_word);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_fcn = f; req_typ = t;
    wc = 0;
    while (!req_ready && wc < 50) begin @(negedge clk); wc++; end
    n_cmp++;
    if (!req_ready) begin
      n_fail++; $display("FAIL ready_timeout addr=%h got ready=0 want 1", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_typ = 3'($urandom);
    lat = 0; nwr = 0; got = 1'b0; wa = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (dmem_req_write_en) begin nwr++; wa = dmem_req_addr; end
      if (resp_valid) got = 1'b1; else lat++;
    end
    r_dat = resp_data; r_err = resp_err; r_lat = lat;
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL resp_timeout addr=%h typ=%0d got none want pulse", a, t); end
    n_cmp++;
    if (lat != e_lat) begin n_fail++; $display("FAIL latency addr=%h typ=%0d fcn=%0d got %0d want %0d", a, t, f, lat, e_lat); end
    n_cmp++;
    if (resp_err !== e_err) begin n_fail++; $display("FAIL resp_err addr=%h typ=%0d got %b want %b", a, t, resp_err, e_err); end
    n_cmp++;
    if (resp_data !== e_dat) begin n_fail++; $display("FAIL resp_data addr=%h typ=%0d got %h want %h", a, t, resp_data, e_dat); end
    n_cmp++;
    if (nwr != e_wr) begin n_fail++; $display("FAIL write_count addr=%h typ=%0d got %0d want %0d", a, t, nwr, e_wr); end
    if (e_wr == 1) begin
      n_cmp++;
      if (wa !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL write_addr got %h want %h", wa, {a[31:2], 2'b00}); end
    end
    n_cmp++;
    if (mem_rd(a[31:2]) !== e_word) begin n_fail++; $display("FAIL mem_word addr=%h got %h want %h", a, mem_rd(a[31:2]), e_word); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, resp_data, dmem_req_addr, dmem_req_data, dmem_req_write_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b rv=%b err=%b dat=%h a=%h d=%h we=%b want all 0",
               req_ready, resp_valid, resp_err, resp_data, dmem_req_addr, dmem_req_data, dmem_req_write_en);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int l;
    do_req(32'h100, 32'hDEAD_BEEF, 1'b1, 3'd3, d, e, l);
    n_cmp++;
    if (l != 2) begin n_fail++; $display("FAIL word_store_latency got %0d want 2", l); end
    do_req(32'h100, 32'h0, 1'b0, 3'd3, d, e, l);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF || l != 3) begin n_fail++; $display("FAIL word_load got %h/%0d want deadbeef/3", d, l); end
  endtask

  task automatic test_rmw();
    logic [31:0] d; logic e; int l;
    poke(32'h200, 32'h1122_3344);
    do_req(32'h202, 32'h0000_00AA, 1'b1, 3'd1, d, e, l);
    n_cmp++;
    if (mem_rd(30'h80) !== 32'h11AA_3344) begin n_fail++; $display("FAIL rmw_byte got %h want 11aa3344", mem_rd(30'h80)); end
    do_req(32'h202, 32'hFFFF_5566, 1'b1, 3'd2, d, e, l);
    n_cmp++;
    if (mem_rd(30'h80) !== 32'h5566_3344 || l != 4) begin n_fail++; $display("FAIL rmw_half got %h/%0d want 55663344/4", mem_rd(30'h80), l); end
  endtask

  task automatic test_load_ext();
    logic [31:0] d; logic e; int l;
    logic [31:0] want [4];
    logic [31:0] addr [4];
    logic [2:0]  typ  [4];
    want = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
    addr = '{32'h302, 32'h302, 32'h302, 32'h300};
    typ  = '{3'd1, 3'd5, 3'd2, 3'd6};
    poke(32'h300, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) begin
      do_req(addr[i], 32'h0, 1'b0, typ[i], d, e, l);
      n_cmp++;
      if (d !== want[i]) begin n_fail++; $display("FAIL load_ext typ=%0d got %h want %h", typ[i], d, want[i]); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic e; int l;
    do_req(32'h101, 32'h1234, 1'b1, 3'd2, d, e, l);
    n_cmp++;
    if (e !== 1'b1 || d !== 32'h0 || l != 1) begin n_fail++; $display("FAIL misaligned_store got err=%b dat=%h lat=%0d want 1/0/1", e, d, l); end
    do_req(32'h102, 32'h0, 1'b0, 3'd3, d, e, l);
    n_cmp++;
    if (e !== 1'b1 || l != 1) begin n_fail++; $display("FAIL misaligned_load got err=%b lat=%0d want 1/1", e, l); end
    do_req(32'h104, 32'h0, 1'b1, 3'd5, d, e, l);
    do_req(32'h104, 32'h0, 1'b0, 3'd7, d, e, l);
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] d; logic e; int l; int bad;
    poke(32'h500, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h501; req_data = 32'hCC; req_fcn = 1'b1; req_typ = 3'd1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (dmem_req_addr !== 32'h500) begin n_fail++; $display("FAIL rmw_read_addr got %h want 500", dmem_req_addr); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_err, resp_data, dmem_req_addr, dmem_req_data, dmem_req_write_en} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs got rdy=%b rv=%b a=%h d=%h we=%b want all 0",
                         req_ready, resp_valid, dmem_req_addr, dmem_req_data, dmem_req_write_en);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (dmem_req_write_en || resp_valid) bad++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (dmem_req_write_en || resp_valid) bad++; end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL mid_reset_activity got %0d cycles want 0", bad); end
    n_cmp++;
    if (mem_rd(30'h140) !== 32'h5566_7788) begin n_fail++; $display("FAIL mid_reset_mem got %h want 55667788", mem_rd(30'h140)); end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got %b want 1", req_ready); end
    do_req(32'h501, 32'hCC, 1'b1, 3'd1, d, e, l);
    n_cmp++;
    if (mem_rd(30'h140) !== 32'h5566_CC88) begin n_fail++; $display("FAIL post_reset_rmw got %h want 5566cc88", mem_rd(30'h140)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [4];
    logic [2:0]  ty [4];
    logic [31:0] ex [4];
    logic [31:0] e_word; logic e_err; int e_lat, e_wr;
    int idx, nresp, cyc, nacc;
    logic acc_now, prev_acc;
    ad = '{32'h600, 32'h605, 32'h60A, 32'h60E};
    ty = '{3'd3, 3'd1, 3'd6, 3'd2};
    for (int i = 0; i < 4; i++) poke(32'h600 + 32'(4 * i), $urandom);
    for (int i = 0; i < 4; i++) model(ad[i], 32'h0, 1'b0, ty[i], ex[i], e_err, e_lat, e_wr, e_word);
    idx = 0; nresp = 0; cyc = 0; nacc = 0; prev_acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_fcn = 1'b0; req_addr = ad[0]; req_typ = ty[0];
    while (nresp < 4 && cyc < 200) begin
      if (resp_valid) begin
        n_cmp++;
        if (resp_data !== ex[nresp] || resp_err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_resp%0d got %h/%b want %h/0", nresp, resp_data, resp_err, ex[nresp]);
        end
        nresp++;
      end
      acc_now = req_valid && req_ready;
      if (acc_now) begin
        nacc++;
        n_cmp++;
        if (prev_acc) begin n_fail++; $display("FAIL b2b_busy got ready=1 after accept want 0"); end
      end
      prev_acc = acc_now;
      @(posedge clk); #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) begin req_addr = ad[idx]; req_typ = ty[idx]; end
        else req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (nacc != 4 || nresp != 4) begin n_fail++; $display("FAIL b2b_counts got acc=%0d resp=%0d want 4/4", nacc, nresp); end
  endtask

  task automatic test_random();
    logic [31:0] a, d; logic e; int l;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                      : (32'h0000_0800 + 32'($urandom_range(0, 15)));
      do_req(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d, e, l);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_rmw();
    test_load_ext();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
